// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller: FSM state encoding and
// a counter-width helper used by the divider and the debouncers.
package cpu_run_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2
  } state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser, stability debouncer and rising-edge pulse for one
// raw board input that is asynchronous to clk.
module debounce_sync
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic dout,
  output logic rise
);

  localparam int            CW     = cnt_width(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sync1_d  = din_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    // Any return to the accepted level restarts the hold-time measurement.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, as real hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;
  assign rise = rise_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the pipelined CPU: conditions the board buttons and
// select switch, and issues one-cycle clock-enable pulses in run or step mode.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int RUN_DIV    = 49_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        sw_sel,
  output logic        cpu_ce,
  output logic        running,
  output logic        disp_sel,
  output logic [31:0] step_count,
  output logic [1:0]  state_o
);

  localparam int            DW     = cnt_width(RUN_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(RUN_DIV);

  logic run_press, step_press;
  logic run_level_unused, step_level_unused, sel_rise_unused;

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst(rst), .din_raw(btn_run), .dout(run_level_unused), .rise(run_press)
  );

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk(clk), .rst(rst), .din_raw(btn_step), .dout(step_level_unused), .rise(step_press)
  );

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk(clk), .rst(rst), .din_raw(sw_sel), .dout(disp_sel), .rise(sel_rise_unused)
  );

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          ce_q, ce_d;
  logic [31:0]   count_q, count_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ce_d    = 1'b0;
    count_d = count_q + {31'd0, ce_q};
    case (state_q)
      ST_PAUSE: begin
        // Run wins over a simultaneous step press.
        if (run_press) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (step_press) begin
          state_d = ST_STEP;
          ce_d    = 1'b1;
        end
      end
      ST_RUN: begin
        // Pausing on the terminal count suppresses that cycle's pulse.
        if (run_press) begin
          state_d = ST_PAUSE;
          div_d   = '0;
        end else if (div_q == DIV_TC) begin
          div_d = '0;
          ce_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_PAUSE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PAUSE;
      div_q   <= '0;
      ce_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ce_q    <= ce_d;
      count_q <= count_d;
    end
  end

  assign cpu_ce     = ce_q;
  assign running    = (state_q == ST_RUN);
  assign step_count = count_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomised bench for cpu_run_ctrl against a behavioural model that tracks
// input history windows and run time with modular arithmetic.
module tb_cpu_run_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_run = 1'b0;
  logic        btn_step = 1'b0;
  logic        sw_sel = 1'b0;
  logic        cpu_ce, running, disp_sel;
  logic [31:0] step_count;
  logic [1:0]  state_o;

  int vecs = 0;
  int errs = 0;

  cpu_run_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .sw_sel(sw_sel),
    .cpu_ce(cpu_ce), .running(running), .disp_sel(disp_sel),
    .step_count(step_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 pause, 1 run, 2 step; m_cur = cycles spent in run.
  logic [1:0]  m_mode = 2'd0;
  int          m_cur = 0;
  bit          m_ce = 1'b0;
  bit          m_ce_n;
  bit          m_upd;
  logic [31:0] m_count = 32'd0;
  logic [2:0]  m_stable = 3'b000;
  logic [2:0]  m_rise = 3'b000;
  logic [2:0]  m_s;
  logic [2:0]  raw_hist[$];
  logic [2:0]  win[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 2'd0; m_cur = 0; m_ce = 1'b0; m_count = 32'd0;
      m_stable = 3'b000; m_rise = 3'b000;
      raw_hist.delete(); win.delete();
    end else begin
      m_count = m_count + 32'(m_ce);
      m_ce_n  = 1'b0;
      case (m_mode)
        2'd0: begin
          if (m_rise[0]) begin m_mode = 2'd1; m_cur = 0; end
          else if (m_rise[1]) begin m_mode = 2'd2; m_ce_n = 1'b1; end
        end
        2'd1: begin
          if (m_rise[0]) m_mode = 2'd0;
          else begin
            if (m_cur % (DIV + 1) == DIV) m_ce_n = 1'b1;
            m_cur++;
          end
        end
        default: m_mode = 2'd0;
      endcase
      m_ce = m_ce_n;
      // A raw level reaches the debouncer two edges after it is sampled.
      raw_hist.push_back({sw_sel, btn_step, btn_run});
      if (raw_hist.size() > 3) void'(raw_hist.pop_front());
      m_s = (raw_hist.size() == 3) ? raw_hist[0] : 3'b000;
      win.push_back(m_s);
      if (win.size() > DEB) void'(win.pop_front());
      m_rise = 3'b000;
      for (int i = 0; i < 3; i++) begin
        m_upd = (win.size() == DEB);
        foreach (win[j]) if (win[j][i] == m_stable[i]) m_upd = 1'b0;
        if (m_upd) begin
          m_stable[i] = ~m_stable[i];
          m_rise[i]   = m_stable[i];
        end
      end
    end
  end

  wire [36:0] dut_vec = {state_o, cpu_ce, running, disp_sel, step_count};
  wire [36:0] exp_vec = {m_mode, m_ce, m_mode == 2'd1, m_stable[2], m_count};

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if (dut_vec !== 37'd0) begin
      errs++; $display("FAIL reset_held: got %h want 0", dut_vec);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); vecs++;
      if (dut_vec !== 37'd0) begin
        errs++; $display("FAIL reset_release: got %h want 0", dut_vec);
      end
    end
  endtask

  task automatic test_run_press();
    btn_run = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) btn_run = 1'b0;
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL run_glitch c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
    end
    vecs++;
    if (running !== 1'b0) begin
      errs++; $display("FAIL glitch_ignored: running=%b want 0", running);
    end
    btn_run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) btn_run = 1'b0;
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL run_hold c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (c == 5 || c == 6) begin
        vecs++;
        if (running !== (c == 6)) begin
          errs++; $display("FAIL run_latency c=%0d: running=%b want %b", c, running, c == 6);
        end
      end
    end
  endtask

  task automatic test_run_mode();
    int pulses = 0;
    logic [31:0] base = m_count;
    btn_step = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c == 10) btn_step = 1'b0;
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL run_mode c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (cpu_ce === 1'b1) pulses++;
    end
    vecs++;
    if (pulses != 5 || step_count - base !== 32'd5 || running !== 1'b1) begin
      errs++;
      $display("FAIL run_mode_total: pulses=%0d count_delta=%0d running=%b want 5 5 1",
               pulses, step_count - base, running);
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    logic [31:0] base;
    btn_run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) btn_run = 1'b0;
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL pause c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
    end
    base = m_count;
    for (int p = 0; p < 3; p++) begin
      btn_step = 1'b1;
      for (int c = 0; c < 20; c++) begin
        if (c == 10) btn_step = 1'b0;
        @(negedge clk); vecs++;
        if (dut_vec !== exp_vec) begin
          errs++; $display("FAIL step p=%0d c=%0d: got %h want %h", p, c, dut_vec, exp_vec);
        end
        if (cpu_ce === 1'b1) pulses++;
      end
      vecs++;
      if (state_o !== 2'd0) begin
        errs++; $display("FAIL step_return p=%0d: state_o=%0d want 0", p, state_o);
      end
    end
    vecs++;
    if (pulses != 3 || step_count - base !== 32'd3) begin
      errs++; $display("FAIL step_total: pulses=%0d count_delta=%0d want 3 3",
                       pulses, step_count - base);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int guard = 0;
    btn_run = 1'b1; btn_step = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 12) begin btn_run = 1'b0; btn_step = 1'b0; end
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL both_press c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (c < 12 && cpu_ce === 1'b1) pulses++;
    end
    vecs++;
    if (pulses != 0 || running !== 1'b1) begin
      errs++; $display("FAIL run_wins: pulses=%0d running=%b want 0 1", pulses, running);
    end
    // Time the press so it reaches the FSM on the divider's terminal cycle.
    while (m_cur % (DIV + 1) != 3 && guard < 30) begin
      @(negedge clk); guard++; vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL tc_align: got %h want %h", dut_vec, exp_vec);
      end
    end
    vecs++;
    if (guard >= 30) begin
      errs++; $display("FAIL tc_align_timeout: waited %0d cycles want <30", guard);
    end
    pulses = 0;
    btn_run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) btn_run = 1'b0;
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL tc_pause c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (cpu_ce === 1'b1) pulses++;
    end
    vecs++;
    if (pulses != 0 || running !== 1'b0) begin
      errs++; $display("FAIL tc_pause_total: pulses=%0d running=%b want 0 0", pulses, running);
    end
  endtask

  task automatic test_sel_and_reset();
    int guard = 0;
    sw_sel = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL sel c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
      if (c == 4 || c == 5) begin
        vecs++;
        if (disp_sel !== (c == 5)) begin
          errs++; $display("FAIL sel_latency c=%0d: disp_sel=%b want %b", c, disp_sel, c == 5);
        end
      end
    end
    btn_run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) btn_run = 1'b0;
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL rerun c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
    end
    while ((m_mode != 2'd1 || m_cur % (DIV + 1) != 7) && guard < 30) begin
      @(negedge clk); guard++; vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL div7_align: got %h want %h", dut_vec, exp_vec);
      end
    end
    vecs++;
    if (guard >= 30) begin
      errs++; $display("FAIL div7_timeout: waited %0d cycles want <30", guard);
    end
    #2 rst = 1'b1;
    #1 vecs++;
    if (dut_vec !== 37'd0) begin
      errs++; $display("FAIL mid_run_reset: got %h want 0", dut_vec);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL post_reset c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 450; c++) begin
      if (c < 420 && $urandom_range(5, 0) == 0) begin
        case ($urandom_range(2, 0))
          0:       btn_run  = ~btn_run;
          1:       btn_step = ~btn_step;
          default: sw_sel   = ~sw_sel;
        endcase
      end
      if (c == 420) begin btn_run = 1'b0; btn_step = 1'b0; end
      @(negedge clk); vecs++;
      if (dut_vec !== exp_vec) begin
        errs++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_press();
    test_run_mode();
    test_step();
    test_back_to_back();
    test_sel_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
